ex_mem_alu_stage: RTL and testbench

- Execute stage of the MIPS pipeline, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code and two forwarded operands, and computes result, zero and overflow.
- Registers the result and the passthrough memory/writeback controls into the EX/MEM pipeline register.
- Supports a pipeline stall (hold) and a flush (bubble insertion) from the hazard unit.

---
 rtl/ex_mem_alu_stage.sv | 162 ++++++++++++++++
 tb/tb_ex_mem_alu_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_alu_stage.sv
// MIPS execute stage: combinational ALU feeding the EX/MEM pipeline register.
// One-cycle latency; stall holds the register, flush inserts a bubble (flush wins).
module ex_mem_alu_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [RADDR-1:0] rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             mem_to_reg_in,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op,
  output logic [WIDTH-1:0] store_data,
  output logic [RADDR-1:0] rd,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             valid_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             ill;
  logic             slt;

  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [WIDTH-1:0] store_data_d, store_data_q;
  logic [RADDR-1:0] rd_d, rd_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic             illegal_op_d, illegal_op_q;
  logic             reg_write_d, reg_write_q;
  logic             mem_read_d, mem_read_q;
  logic             mem_write_d, mem_write_q;
  logic             mem_to_reg_d, mem_to_reg_q;
  logic             valid_d, valid_q;

  // SLT uses a true signed compare so it stays correct when a-b overflows.
  assign slt = ($signed(op_a) < $signed(op_b));

  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (alu_ctrl)
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_ADD: begin
        res = op_a + op_b;
        ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        res = op_a - op_b;
        ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR: res = ~(op_a | op_b);
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    zero_d       = zero_q;
    overflow_d   = overflow_q;
    illegal_op_d = illegal_op_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    valid_d      = valid_q;
    if (flush) begin
      alu_result_d = '0;
      store_data_d = '0;
      rd_d         = '0;
      zero_d       = 1'b0;
      overflow_d   = 1'b0;
      illegal_op_d = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      valid_d      = 1'b0;
    end else if (!stall) begin
      // Bubbles still carry datapath values but never side effects.
      alu_result_d = res;
      store_data_d = store_data_in;
      rd_d         = rd_in;
      zero_d       = (res == '0);
      overflow_d   = ovf & valid_in;
      illegal_op_d = ill & valid_in;
      reg_write_d  = reg_write_in & valid_in;
      mem_read_d   = mem_read_in & valid_in;
      mem_write_d  = mem_write_in & valid_in;
      mem_to_reg_d = mem_to_reg_in & valid_in;
      valid_d      = valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      illegal_op_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      zero_q       <= zero_d;
      overflow_q   <= overflow_d;
      illegal_op_q <= illegal_op_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      valid_q      <= valid_d;
    end
  end

  assign alu_result = alu_result_q;
  assign store_data = store_data_q;
  assign rd         = rd_q;
  assign zero       = zero_q;
  assign overflow   = overflow_q;
  assign illegal_op = illegal_op_q;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// Directed bench for ex_mem_alu_stage: ALU ops, overflow, SLT signedness, stall/flush, bubbles, async reset.
module tb_ex_mem_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        valid_in, stall, flush;
  logic [31:0] alu_result, store_data;
  logic        zero, overflow, illegal_op;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, mem_to_reg, valid_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_alu_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .store_data_in(store_data_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .valid_in(valid_in), .stall(stall), .flush(flush), .alu_result(alu_result),
    .zero(zero), .overflow(overflow), .illegal_op(illegal_op), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .valid_out(valid_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic v);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    valid_in = v;
  endtask

  task automatic set_ctl(input logic rw, input logic mr, input logic mw, input logic m2r);
    reg_write_in  = rw;
    mem_read_in   = mr;
    mem_write_in  = mw;
    mem_to_reg_in = m2r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_op(4'b0010, 32'd0, 32'd0, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    store_data_in = '0;
    rd_in = '0;
    tick();
    checks++; if ({alu_result, zero, valid_out, reg_write} !== 35'd0) begin failures++; $display("FAIL reset_initial got=%h exp=0", {alu_result, zero, valid_out, reg_write}); end
    @(negedge clk);
    rst_n = 1'b1;
    set_op(4'b0010, 32'd1, 32'd2, 1'b1);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    store_data_in = 32'hCAFE_F00D;
    rd_in = 5'd9;
    tick();
    checks++; if (alu_result !== 32'd3 || valid_out !== 1'b1) begin failures++; $display("FAIL reset_first_load got=%h/%b exp=3/1", alu_result, valid_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({alu_result, store_data, rd, zero, overflow, illegal_op, reg_write, mem_read, mem_write, mem_to_reg, valid_out} !== 77'd0) begin failures++; $display("FAIL reset_async got=%h exp=0", {alu_result, store_data, rd, valid_out}); end
    tick();
    tick();
    checks++; if ({alu_result, store_data, rd, reg_write, mem_write, valid_out} !== 72'd0) begin failures++; $display("FAIL reset_held got=%h exp=0", {alu_result, store_data, rd, valid_out}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    set_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    store_data_in = 32'hDEAD_BEEF;
    rd_in = 5'd5;
    tick();
    checks++; if (alu_result !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_result got=%h exp=80000000", alu_result); end
    checks++; if (overflow !== 1'b1 || zero !== 1'b0) begin failures++; $display("FAIL add_ovf_flags got ovf=%b zero=%b exp ovf=1 zero=0", overflow, zero); end
    checks++; if (store_data !== 32'hDEAD_BEEF || rd !== 5'd5 || reg_write !== 1'b1) begin failures++; $display("FAIL add_passthru got sd=%h rd=%0d rw=%b exp sd=deadbeef rd=5 rw=1", store_data, rd, reg_write); end
    set_op(4'b0110, 32'd5, 32'd5, 1'b1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL sub_zero got res=%h zero=%b ovf=%b exp 0/1/0", alu_result, zero, overflow); end
    checks++; if (mem_read !== 1'b1 || mem_to_reg !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL sub_ctl got mr=%b m2r=%b mw=%b exp 1/1/0", mem_read, mem_to_reg, mem_write); end
    set_op(4'b0110, 32'h8000_0000, 32'd1, 1'b1);
    tick();
    checks++; if (alu_result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin failures++; $display("FAIL sub_ovf got res=%h ovf=%b exp 7fffffff/1", alu_result, overflow); end
  endtask

  task automatic test_slt();
    set_op(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b1);
    tick();
    checks++; if (alu_result !== 32'd1 || zero !== 1'b0) begin failures++; $display("FAIL slt_neg got res=%h zero=%b exp 1/0", alu_result, zero); end
    set_op(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL slt_ovf got res=%h zero=%b ovf=%b exp 0/1/0", alu_result, zero, overflow); end
  endtask

  task automatic test_logic_illegal();
    set_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1'b1);
    tick();
    checks++; if (alu_result !== 32'h0000_F000) begin failures++; $display("FAIL and got=%h exp=0000f000", alu_result); end
    set_op(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 1'b1);
    tick();
    checks++; if (alu_result !== 32'h0000_FFF0) begin failures++; $display("FAIL or got=%h exp=0000fff0", alu_result); end
    set_op(4'b1100, 32'd0, 32'd0, 1'b1);
    tick();
    checks++; if (alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin failures++; $display("FAIL nor got res=%h zero=%b exp ffffffff/0", alu_result, zero); end
    set_op(4'b0011, 32'h1234_5678, 32'h1111_1111, 1'b1);
    tick();
    checks++; if (alu_result !== 32'd0 || zero !== 1'b1 || illegal_op !== 1'b1) begin failures++; $display("FAIL illegal got res=%h zero=%b ill=%b exp 0/1/1", alu_result, zero, illegal_op); end
    set_op(4'b0011, 32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    checks++; if (illegal_op !== 1'b0 || valid_out !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL illegal_bubble got ill=%b vld=%b rw=%b exp 0/0/0", illegal_op, valid_out, reg_write); end
  endtask

  task automatic test_stall_flush();
    set_op(4'b0010, 32'd3, 32'd4, 1'b1);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    rd_in = 5'd7;
    store_data_in = 32'h0000_AAAA;
    tick();
    checks++; if (alu_result !== 32'd7 || reg_write !== 1'b1 || valid_out !== 1'b1) begin failures++; $display("FAIL stall_preload got res=%h rw=%b vld=%b exp 7/1/1", alu_result, reg_write, valid_out); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'b0001, 32'h100 + i, 32'h55, 1'b1);
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      rd_in = 5'd20 + 5'(i);
      store_data_in = 32'hBEEF_0000 + i;
      tick();
      checks++; if (alu_result !== 32'd7 || reg_write !== 1'b1 || rd !== 5'd7 || store_data !== 32'h0000_AAAA || mem_write !== 1'b0 || valid_out !== 1'b1) begin failures++; $display("FAIL stall_hold cyc=%0d got res=%h rw=%b rd=%0d sd=%h mw=%b exp 7/1/7/0000aaaa/0", i, alu_result, reg_write, rd, store_data, mem_write); end
    end
    flush = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0 || reg_write !== 1'b0 || alu_result !== 32'd0 || mem_read !== 1'b0 || rd !== 5'd0 || zero !== 1'b0) begin failures++; $display("FAIL flush_stall got vld=%b rw=%b res=%h mr=%b rd=%0d zero=%b exp all 0", valid_out, reg_write, alu_result, mem_read, rd, zero); end
    flush = 1'b0;
    stall = 1'b0;
    set_op(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 1'b1);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    rd_in = 5'd11;
    tick();
    checks++; if (alu_result !== 32'h0000_FFF0 || valid_out !== 1'b1 || reg_write !== 1'b1 || rd !== 5'd11) begin failures++; $display("FAIL after_flush got res=%h vld=%b rw=%b rd=%0d exp fff0/1/1/11", alu_result, valid_out, reg_write, rd); end
  endtask

  task automatic test_bubble();
    set_op(4'b0010, 32'd1, 32'd1, 1'b0);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (valid_out !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL bubble_ctl got vld=%b mw=%b rw=%b exp 0/0/0", valid_out, mem_write, reg_write); end
    checks++; if (alu_result !== 32'd2 || zero !== 1'b0) begin failures++; $display("FAIL bubble_data got res=%h zero=%b exp 2/0", alu_result, zero); end
    set_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0);
    tick();
    checks++; if (overflow !== 1'b0 || alu_result !== 32'h8000_0000) begin failures++; $display("FAIL bubble_ovf got ovf=%b res=%h exp 0/80000000", overflow, alu_result); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt();
    test_logic_illegal();
    test_stall_flush();
    test_bubble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
